calc2_port_responder: RTL and testbench

- Behavioural responder for one calc2 request port. It is the far end of the port that the calc2 bench interface drives on negedge PClk.
- Samples the two-cycle request on posedge PClk: command, tag and operand 1 in the first cycle, operand 2 in the second.
- Computes the result and returns it on the port's response bus (out_resp/out_data/out_tag) after a programmable latency, in arrival order.
- Four instances are the golden reference DUT for checker and monitor bring-up.

---
 rtl/calc2_pkg.sv | 39 +++
 rtl/calc2_alu.sv | 49 ++++
 rtl/calc2_port_responder.sv | 147 ++++++++++++++
 tb/tb_calc2_port_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
`default_nettype none
// ============================================================================
// calc2_pkg : shared widths, command/response encodings and queue entry type
// Rev 1.0
// ============================================================================
package calc2_pkg;

    localparam int CALC_CMD_WIDTH  = 4;
    localparam int CALC_DATA_WIDTH = 32;
    localparam int TAG_WIDTH       = 2;
    localparam int AGE_WIDTH       = 4;

    typedef enum logic [CALC_CMD_WIDTH-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef struct packed {
        resp_e                      resp;
        logic [CALC_DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]       tag;
        logic [AGE_WIDTH-1:0]       age;
    } resp_entry_t;

    function automatic logic [AGE_WIDTH-1:0] age_inc(input logic [AGE_WIDTH-1:0] a);
        return (a == '1) ? a : a + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc2_alu.sv
`default_nettype none
// ============================================================================
// calc2_alu : combinational calc2 arithmetic, cmd/op1/op2 -> {resp, data}
// Rev 1.0
// ============================================================================
module calc2_alu
    import calc2_pkg::*;
(
    input  logic [CALC_CMD_WIDTH-1:0]  cmd_i,
    input  logic [CALC_DATA_WIDTH-1:0] op1_i,
    input  logic [CALC_DATA_WIDTH-1:0] op2_i,
    output resp_e                      resp_o,
    output logic [CALC_DATA_WIDTH-1:0] data_o
);

    logic [CALC_DATA_WIDTH:0] w_sum;

    assign w_sum = {1'b0, op1_i} + {1'b0, op2_i};

    always_comb begin
        resp_o = RESP_ERR;
        data_o = '0;
        case (cmd_i)
            CMD_ADD: begin
                if (!w_sum[CALC_DATA_WIDTH]) begin
                    resp_o = RESP_OK;
                    data_o = w_sum[CALC_DATA_WIDTH-1:0];
                end
            end
            CMD_SUB: begin
                if (op2_i <= op1_i) begin
                    resp_o = RESP_OK;
                    data_o = op1_i - op2_i;
                end
            end
            CMD_SHL: begin
                resp_o = RESP_OK;
                data_o = op1_i << op2_i[4:0];
            end
            CMD_SHR: begin
                resp_o = RESP_OK;
                data_o = op1_i >> op2_i[4:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/calc2_port_responder.sv
`default_nettype none
// ============================================================================
// calc2_port_responder : two-cycle calc2 request capture, in-order delayed
// response queue. Optional CALC2_RESP_STATS_EN adds saturating stat counters.
// Rev 1.0
// ============================================================================
module calc2_port_responder
    import calc2_pkg::*;
#(
    parameter int RESP_LATENCY = 3,
    parameter int QDEPTH       = 4
) (
    input  logic                       PClk,
    input  logic                       Rst,
    input  logic [CALC_CMD_WIDTH-1:0]  req_cmd_in,
    input  logic [CALC_DATA_WIDTH-1:0] req_data_in,
    input  logic [TAG_WIDTH-1:0]       req_tag_in,
    output logic [1:0]                 out_resp,
    output logic [CALC_DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]       out_tag
`ifdef CALC2_RESP_STATS_EN
    ,
    output logic [15:0]                stat_req_cnt,
    output logic [15:0]                stat_err_cnt,
    output logic [15:0]                stat_drop_cnt
`endif
);

    localparam int                   c_PTR_W = $clog2(QDEPTH);
    localparam logic [AGE_WIDTH-1:0] c_LAT   = AGE_WIDTH'(RESP_LATENCY);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [CALC_CMD_WIDTH-1:0]  cmd_q;
    logic [TAG_WIDTH-1:0]       tag_q;
    logic [CALC_DATA_WIDTH-1:0] op1_q;

    resp_entry_t                q_q [QDEPTH];
    logic [QDEPTH-1:0]          vld_q;
    logic [c_PTR_W-1:0]         rd_q, wr_q;

    resp_e                      w_alu_resp;
    logic [CALC_DATA_WIDTH-1:0] w_alu_data;
    logic                       w_op2, w_dup, w_push, w_drop, w_pop, w_full;
    resp_entry_t                w_head;

    calc2_alu u_alu (
        .cmd_i  (cmd_q),
        .op1_i  (op1_q),
        .op2_i  (req_data_in),
        .resp_o (w_alu_resp),
        .data_o (w_alu_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_cmd_in != '0) state_d = ST_OP2;
            ST_OP2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A tag still in the queue (including a head being popped this cycle) is outstanding.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (vld_q[i] && (q_q[i].tag == tag_q)) w_dup = 1'b1;
        end
    end

    assign w_op2  = (state_q == ST_OP2);
    assign w_push = w_op2 && !w_dup;
    assign w_drop = w_op2 && w_dup;
    assign w_full = &vld_q;
    assign w_head = q_q[rd_q];
    assign w_pop  = vld_q[rd_q] && (age_inc(w_head.age) >= c_LAT);

    always_ff @(posedge PClk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            tag_q    <= '0;
            op1_q    <= '0;
            vld_q    <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && (req_cmd_in != '0)) begin
                cmd_q <= req_cmd_in;
                tag_q <= req_tag_in;
                op1_q <= req_data_in;
            end
            for (int i = 0; i < QDEPTH; i++) begin
                q_q[i].age <= age_inc(q_q[i].age);
            end
            if (w_pop) begin
                vld_q[rd_q] <= 1'b0;
                rd_q        <= rd_q + 1'b1;
                out_resp    <= w_head.resp;
                out_data    <= w_head.data;
                out_tag     <= w_head.tag;
            end else begin
                out_resp <= '0;
                out_data <= '0;
                out_tag  <= '0;
            end
            if (w_push) begin
                q_q[wr_q]   <= '{resp: w_alu_resp, data: w_alu_data, tag: tag_q, age: '0};
                vld_q[wr_q] <= 1'b1;
                wr_q        <= wr_q + 1'b1;
            end
        end
    end

    a_no_push_full: assert property (@(posedge PClk) disable iff (Rst) !(w_push && w_full));

`ifdef CALC2_RESP_STATS_EN
    logic [15:0] req_cnt_q, err_cnt_q, drop_cnt_q;

    always_ff @(posedge PClk) begin
        if (Rst) begin
            req_cnt_q  <= '0;
            err_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (w_push && (req_cnt_q != '1)) req_cnt_q <= req_cnt_q + 1'b1;
            if (w_pop && (w_head.resp == RESP_ERR) && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
            if (w_drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign stat_req_cnt  = req_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc2_port_responder.sv
`default_nettype none
// ============================================================================
// tb_calc2_port_responder : directed + randomized bench with a schedule-based
// reference model of the response stream.
// Rev 1.0
// ============================================================================
module tb_calc2_port_responder;

    localparam int LAT = 3;

    logic        PClk = 1'b0;
    logic        Rst  = 1'b1;
    logic [3:0]  req_cmd_in  = '0;
    logic [31:0] req_data_in = '0;
    logic [1:0]  req_tag_in  = '0;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
`ifdef CALC2_RESP_STATS_EN
    logic [15:0] stat_req_cnt, stat_err_cnt, stat_drop_cnt;
`endif

    calc2_port_responder #(.RESP_LATENCY(LAT), .QDEPTH(4)) dut (
        .PClk        (PClk),
        .Rst         (Rst),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .req_tag_in  (req_tag_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .out_tag     (out_tag)
`ifdef CALC2_RESP_STATS_EN
        ,
        .stat_req_cnt  (stat_req_cnt),
        .stat_err_cnt  (stat_err_cnt),
        .stat_drop_cnt (stat_drop_cnt)
`endif
    );

    always #5 PClk = ~PClk;

    typedef struct {
        int          t;
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur;
    int  cyc    = 0;
    int  last_t = 0;
    int  total  = 0;
    int  bad    = 0;
    int  m_req  = 0;
    int  m_err  = 0;
    int  m_drop = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Reference arithmetic straight from the command definitions.
    function automatic void ref_calc(input logic [3:0] cmd, input logic [31:0] a,
                                     input logic [31:0] b, output logic [1:0] r,
                                     output logic [31:0] d);
        longint unsigned s;
        r = 2'd2;
        d = 32'd0;
        case (cmd)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
            end
            4'd2: if (a >= b) begin r = 2'd1; d = a - b; end
            4'd5: begin r = 2'd1; d = a << (b % 32); end
            4'd6: begin r = 2'd1; d = a >> (b % 32); end
            default: ;
        endcase
    endfunction

    // Called at the negedge before the operand-2 capture edge k = cyc+1.
    function automatic void model_capture(input logic [3:0] cmd, input logic [1:0] tag,
                                          input logic [31:0] a, input logic [31:0] b);
        ev_t e;
        int  k;
        k = cyc + 1;
        foreach (exp_q[i]) begin
            if (exp_q[i].tag == tag) begin
                m_drop++;
                return;
            end
        end
        ref_calc(cmd, a, b, e.resp, e.data);
        e.tag  = tag;
        e.t    = (k + LAT > last_t + 1) ? k + LAT : last_t + 1;
        last_t = e.t;
        m_req++;
        exp_q.push_back(e);
    endfunction

    always begin
        @(posedge PClk);
        cyc++;
        #1;
        if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
            cur = exp_q.pop_front();
            if (cur.resp == 2'd2) m_err++;
            chk("resp", 32'(out_resp), 32'(cur.resp));
            chk("data", out_data, cur.data);
            chk("tag",  32'(out_tag),  32'(cur.tag));
        end else begin
            chk("idle_resp", 32'(out_resp), 32'd0);
            chk("idle_data", out_data, 32'd0);
            chk("idle_tag",  32'(out_tag),  32'd0);
        end
    end

    task automatic first_half(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] a);
        @(negedge PClk);
        Rst         = 1'b0;
        req_cmd_in  = cmd;
        req_tag_in  = tag;
        req_data_in = a;
    endtask

    task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op2_cmd);
        first_half(cmd, tag, a);
        @(negedge PClk);
        req_cmd_in  = op2_cmd;
        req_tag_in  = 2'($urandom);
        req_data_in = b;
        model_capture(cmd, tag, a, b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PClk);
            Rst         = 1'b0;
            req_cmd_in  = '0;
            req_tag_in  = 2'($urandom);
            req_data_in = $urandom;
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge PClk);
        Rst         = 1'b1;
        req_cmd_in  = 4'($urandom);
        req_data_in = $urandom;
        exp_q.delete();
        last_t = 0;
        m_req  = 0;
        m_err  = 0;
        m_drop = 0;
        repeat (n - 1) begin
            @(negedge PClk);
            req_cmd_in  = 4'($urandom);
            req_data_in = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_op();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
    endfunction

    logic [3:0] cmd_tbl [7];

    initial begin
        cmd_tbl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9, 4'd15};

        do_reset(2);
        idle(2);

        send(4'd1, 2'd1, 32'd5, 32'd7, 4'd0);
        idle(6);

        send(4'd1, 2'd2, 32'hFFFF_FFFF, 32'd1, 4'd0);
        send(4'd2, 2'd3, 32'd3, 32'd4, 4'd0);
        send(4'd5, 2'd0, 32'd1, 32'h0000_0024, 4'd0);
        send(4'd6, 2'd1, 32'h8000_0000, 32'd31, 4'd0);
        idle(10);

        for (int t = 0; t < 4; t++) send(4'd1, 2'(t), $urandom, rand_op(), 4'd0);
        send(4'd2, 2'd0, 32'd9, 32'd4, 4'd0);
        idle(12);
`ifdef CALC2_RESP_STATS_EN
        chk("stat_drop", 32'(stat_drop_cnt), 32'(m_drop));
`endif

        send(4'd9, 2'd0, 32'd123, 32'd456, 4'd0);
        send(4'd1, 2'd1, 32'd10, 32'd20, 4'd6);
        idle(8);

        send(4'd1, 2'd2, 32'd1, 32'd2, 4'd0);
        send(4'd2, 2'd3, 32'd8, 32'd2, 4'd0);
        first_half(4'd1, 2'd0, 32'd77);
        do_reset(1);
        idle(8);
        send(4'd1, 2'd1, 32'd1, 32'd1, 4'd0);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                if ($urandom_range(0, 1) == 1) first_half(cmd_tbl[$urandom_range(0, 6)], 2'($urandom), $urandom);
                do_reset($urandom_range(1, 3));
            end
            send(cmd_tbl[$urandom_range(0, 6)], 2'($urandom), rand_op(), rand_op(),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 4));
        end
        idle(80);

`ifdef CALC2_RESP_STATS_EN
        chk("stat_req",  32'(stat_req_cnt),  32'(m_req));
        chk("stat_err",  32'(stat_err_cnt),  32'(m_err));
        chk("stat_drop", 32'(stat_drop_cnt), 32'(m_drop));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
